// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and default timing constants for the reset sequencer
//
// Contents:
//   state_e   - sequencer FSM states
//   cause_e   - encoding reported on last_cause
//   DEF_*     - default cycle counts used as parameter defaults by reset_sequencer
//   max_of    - helper used to size the shared phase counter
package reset_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST     = 3'd0,
        WAIT_LOCK   = 3'd1,
        LOCK_STABLE = 3'd2,
        PERIPH_REL  = 3'd3,
        CORE_REL    = 3'd4,
        RUN         = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR       = 2'd0,
        CAUSE_BUTTON    = 2'd1,
        CAUSE_LOCK_LOST = 2'd2,
        CAUSE_TIMEOUT   = 2'd3
    } cause_e;

    localparam int DEF_PB_DEBOUNCE_CYCLES  = 250000;
    localparam int DEF_PLL_RST_CYCLES      = 8;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_STAGE_GAP_CYCLES    = 16;

    localparam logic [3:0] RETRY_MAX = 4'd15;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer with asynchronous clear
//
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low clear, output forced to 0
//   d     - asynchronous input
//   q     - input resynchronized to clk, two cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged PLL / peripheral / core reset release with button and lock supervision
//
// Ports:
//   clock        - system clock
//   reset        - asynchronous active-low global reset
//   pb_reset     - raw push-button, active-high, asynchronous
//   pll_locked   - clock-wizard lock flag, asynchronous
//   pll_reset    - active-high reset to the clock wizard
//   periph_reset - active-high reset to UART/LED logic
//   core_reset   - active-high reset to core and caches
//   sys_ready    - high only while in RUN
//   retry_count  - saturating count of lock timeouts, cleared only by global reset
//   last_cause   - cause of the most recent sequence (see cause_e)
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int PB_DEBOUNCE_CYCLES  = DEF_PB_DEBOUNCE_CYCLES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pb_reset,
    input  logic       pll_locked,
    output logic       pll_reset,
    output logic       periph_reset,
    output logic       core_reset,
    output logic       sys_ready,
    output logic [3:0] retry_count,
    output logic [1:0] last_cause
);

    // One phase counter is shared by every timed state, so it is sized for the longest phase.
    localparam int PH_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                   max_of(LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES));
    localparam int CNT_W  = $clog2(PH_MAX + 1);
    localparam int DB_W   = $clog2(PB_DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(PB_DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_FULL     = DB_W'(PB_DEBOUNCE_CYCLES);

    logic pb_s;
    logic locked_s;

    sync_2ff u_sync_pb (
        .clk   (clock),
        .rst_n (reset),
        .d     (pb_reset),
        .q     (pb_s)
    );

    sync_2ff u_sync_lock (
        .clk   (clock),
        .rst_n (reset),
        .d     (pll_locked),
        .q     (locked_s)
    );

    state_e           state_q, state_d;
    cause_e           cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             pll_reset_q, pll_reset_d;
    logic             periph_reset_q, periph_reset_d;
    logic             core_reset_q, core_reset_d;
    logic             sys_ready_q, sys_ready_d;

    logic press;
    logic lock_lost;

    // The debounce counter saturates at the full count while the button stays high,
    // so a long hold yields exactly one press; only a low sample re-arms it.
    always_comb begin
        db_cnt_d = db_cnt_q;
        if (!pb_s) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_FULL) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign press     = pb_s && (db_cnt_q == DB_LAST);
    assign lock_lost = !locked_s && (state_q inside {LOCK_STABLE, PERIPH_REL, CORE_REL, RUN});

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        cnt_d          = cnt_q + CNT_W'(1);
        retry_d        = retry_q;
        pll_reset_d    = pll_reset_q;
        periph_reset_d = periph_reset_q;
        core_reset_d   = core_reset_q;
        sys_ready_d    = sys_ready_q;

        // Button beats lock loss, which beats every per-state transition (including timeout).
        if (press) begin
            state_d        = PLL_RST;
            cause_d        = CAUSE_BUTTON;
            cnt_d          = '0;
            pll_reset_d    = 1'b1;
            periph_reset_d = 1'b1;
            core_reset_d   = 1'b1;
            sys_ready_d    = 1'b0;
        end else if (lock_lost) begin
            state_d        = WAIT_LOCK;
            cause_d        = CAUSE_LOCK_LOST;
            cnt_d          = '0;
            pll_reset_d    = 1'b0;
            periph_reset_d = 1'b1;
            core_reset_d   = 1'b1;
            sys_ready_d    = 1'b0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == PLL_LAST) begin
                        state_d     = WAIT_LOCK;
                        cnt_d       = '0;
                        pll_reset_d = 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = LOCK_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = PLL_RST;
                        cnt_d       = '0;
                        cause_d     = CAUSE_TIMEOUT;
                        pll_reset_d = 1'b1;
                        if (retry_q != RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                LOCK_STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d        = PERIPH_REL;
                        cnt_d          = '0;
                        periph_reset_d = 1'b0;
                    end
                end
                PERIPH_REL: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d      = CORE_REL;
                        cnt_d        = '0;
                        core_reset_d = 1'b0;
                    end
                end
                CORE_REL: begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    sys_ready_d = 1'b1;
                end
                RUN: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d        = PLL_RST;
                    cnt_d          = '0;
                    pll_reset_d    = 1'b1;
                    periph_reset_d = 1'b1;
                    core_reset_d   = 1'b1;
                    sys_ready_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= PLL_RST;
            cause_q        <= CAUSE_POR;
            cnt_q          <= '0;
            db_cnt_q       <= '0;
            retry_q        <= 4'd0;
            pll_reset_q    <= 1'b1;
            periph_reset_q <= 1'b1;
            core_reset_q   <= 1'b1;
            sys_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cause_q        <= cause_d;
            cnt_q          <= cnt_d;
            db_cnt_q       <= db_cnt_d;
            retry_q        <= retry_d;
            pll_reset_q    <= pll_reset_d;
            periph_reset_q <= periph_reset_d;
            core_reset_q   <= core_reset_d;
            sys_ready_q    <= sys_ready_d;
        end
    end

    assign pll_reset    = pll_reset_q;
    assign periph_reset = periph_reset_q;
    assign core_reset   = core_reset_q;
    assign sys_ready    = sys_ready_q;
    assign retry_count  = retry_q;
    assign last_cause   = cause_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter PB_DEBOUNCE_CYCLES, default 250000: cycles the synchronized button must stay asserted to count as a press.
REQ-002 Parameter PLL_RST_CYCLES, default 8: length of the pll_reset pulse.
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024: cycles pll_locked must stay high before any release.
REQ-004 Parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum wait for lock before the PLL is reset again.
REQ-005 Parameter STAGE_GAP_CYCLES, default 16: delay between periph_reset release and core_reset release.
REQ-006 Port: clock, input, 1, single system clock.
REQ-007 Port: reset, input, 1, asynchronous active-low global reset.
REQ-008 Port: pb_reset, input, 1, raw push-button, active-high, asynchronous to clock.
REQ-009 Port: pll_locked, input, 1, clock-wizard locked flag, asynchronous to clock.
REQ-010 Port: pll_reset, output, 1, active-high reset to the clock wizard.
REQ-011 Port: periph_reset, output, 1, active-high reset to UART/LED logic.
REQ-012 Port: core_reset, output, 1, active-high reset to the core and caches.
REQ-013 Port: sys_ready, output, 1, high only in RUN.
REQ-014 Port: retry_count, output, 4, saturating count of lock timeouts.
REQ-015 Port: last_cause, output, 2, cause of the last sequence: 0 POR, 1 button, 2 lock lost, 3 timeout.

Function
REQ-016 pb_reset and pll_locked SHALL each pass through a 2-flop synchronizer before use; the added latency is 2 cycles.
REQ-017 A press SHALL be detected once the synchronized pb_reset has been high for PB_DEBOUNCE_CYCLES consecutive cycles; any low sample clears the counter.
REQ-018 Each hold generates one press event; a new press requires the button to go low and then repeat the full debounce.
REQ-019 The FSM states are PLL_RST, WAIT_LOCK, LOCK_STABLE, PERIPH_REL, CORE_REL, RUN.
REQ-020 PLL_RST: pll_reset=1 for PLL_RST_CYCLES cycles, then WAIT_LOCK.
REQ-021 WAIT_LOCK: locked=1 -> LOCK_STABLE; the timeout counter reaching LOCK_TIMEOUT_CYCLES -> PLL_RST, last_cause=3, retry_count+1 (saturates at 15).
REQ-022 LOCK_STABLE: locked held for LOCK_STABLE_CYCLES -> PERIPH_REL; locked dropping -> WAIT_LOCK with the counter cleared.
REQ-023 PERIPH_REL: periph_reset deasserts on entry; after STAGE_GAP_CYCLES -> CORE_REL.
REQ-024 CORE_REL: core_reset deasserts on entry; next cycle -> RUN.
REQ-025 RUN: sys_ready=1.
REQ-026 In any state from LOCK_STABLE onward, locked dropping -> WAIT_LOCK, last_cause=2.
REQ-027 A press event in any state -> PLL_RST, last_cause=1; the press takes priority over lock loss and timeout in the same cycle.
REQ-028 Outside PERIPH_REL, CORE_REL and RUN, periph_reset and core_reset SHALL be 1, applied in the same cycle as the state change.
REQ-029 core_reset is never 0 while periph_reset is 1.
REQ-030 All outputs are registered.
REQ-031 retry_count clears only on global reset.

Reset
REQ-032 Global reset asserted, including mid-sequence, SHALL immediately force state=PLL_RST, pll_reset=1, periph_reset=1, core_reset=1, sys_ready=0, retry_count=0, last_cause=0, and clear all counters.
REQ-033 Deassertion starts the PLL_RST pulse count on the first clock edge.

Structure
REQ-034 Package reset_seq_pkg holds the state enum, the cause encoding, and the default parameter constants.
REQ-035 Sub-module sync_2ff (1-bit, asynchronous active-low clear to 0) is instantiated twice.
REQ-036 Counters are sized by $clog2 of their parameter; one shared counter serves the FSM phases and a separate counter serves debounce.

Verification (sim parameters: PB_DEBOUNCE_CYCLES=10, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=50, STAGE_GAP_CYCLES=3)
REQ-037 Release reset, raise locked at cycle 20 -> pll_reset low after 4 cycles; periph_reset falls 8+2 cycles after locked; core_reset falls 3 cycles later; sys_ready=1 next cycle; last_cause=0.
REQ-038 Locked never rises -> pll_reset re-pulses every 54 cycles; retry_count counts to 15 and holds; last_cause=3.
REQ-039 In RUN, drop locked for 1 cycle -> core_reset and periph_reset are 1 within 3 cycles, state returns to WAIT_LOCK, last_cause=2, and re-release follows REQ-037 timing.
REQ-040 Button glitch of 9 cycles -> no effect; 10+ cycles -> PLL_RST, last_cause=1; holding for 100 cycles produces one sequence only.
REQ-041 Assert reset mid-PERIPH_REL -> all outputs return to reset values asynchronously, before the next clock edge.
REQ-042 Press and lock loss in the same cycle -> last_cause=1.
